// File: rtl/uart_tx.sv
// uart_tx: 16-bit UART transmitter for the FPGA serial link.
// Frame: start bit (low), 16 data bits LSB first, stop bit (high),
// each bit held CLOCKS_POR_BIT clock cycles. All outputs are registered.
// Optional build macro UART_TX_PARIDADE_EN inserts an even-parity bit
// between data bit 15 and the stop bit (19-bit frame).
module uart_tx #(
  parameter int CLOCKS_POR_BIT = 5209
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iniciarEnvio,
  input  logic [15:0] dadosParaEnviar,
  output logic        bitSerialSaida,
  output logic        transmissaoAtiva,
  output logic        transmissaoConcluida
);

  localparam logic [12:0] LAST_COUNT = 13'(CLOCKS_POR_BIT - 1);

  typedef enum logic [2:0] {
    ESPERA   = 3'd0,
    INICIO   = 3'd1,
    DADOS    = 3'd2,
    PARADA   = 3'd3,
`ifdef UART_TX_PARIDADE_EN
    PARIDADE = 3'd5,
`endif
    LIMPEZA  = 3'd4
  } state_t;

  state_t      state, state_n;
  logic [12:0] count, count_n;
  logic [3:0]  indice, indice_n;
  logic [15:0] word, word_n;
  logic        tx, tx_n;
  logic        active, active_n;
  logic        done, done_n;
  logic        bit_end;
`ifdef UART_TX_PARIDADE_EN
  logic        parity, parity_n;
`endif

  assign bit_end              = (count == LAST_COUNT);
  assign bitSerialSaida       = tx;
  assign transmissaoAtiva     = active;
  assign transmissaoConcluida = done;

  // Register the state, datapath and the registered outputs; reset parks the line high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= ESPERA;
      count  <= '0;
      indice <= '0;
      word   <= '0;
      tx     <= 1'b1;
      active <= 1'b0;
      done   <= 1'b0;
`ifdef UART_TX_PARIDADE_EN
      parity <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      count  <= count_n;
      indice <= indice_n;
      word   <= word_n;
      tx     <= tx_n;
      active <= active_n;
      done   <= done_n;
`ifdef UART_TX_PARIDADE_EN
      parity <= parity_n;
`endif
    end
  end

  // Next-state and next-output logic; every register holds unless a state changes it.
  always_comb begin
    state_n  = state;
    count_n  = count;
    indice_n = indice;
    word_n   = word;
    tx_n     = tx;
    active_n = active;
    done_n   = done;
`ifdef UART_TX_PARIDADE_EN
    parity_n = parity;
`endif
    case (state)
      ESPERA: begin
        tx_n     = 1'b1;
        done_n   = 1'b0;
        count_n  = '0;
        indice_n = '0;
        if (iniciarEnvio) begin
          word_n   = dadosParaEnviar;
          active_n = 1'b1;
          state_n  = INICIO;
`ifdef UART_TX_PARIDADE_EN
          parity_n = ^dadosParaEnviar;
`endif
        end
      end
      INICIO: begin
        tx_n = 1'b0;
        if (bit_end) begin
          count_n = '0;
          state_n = DADOS;
        end else begin
          count_n = count + 13'd1;
        end
      end
      DADOS: begin
        tx_n = word[indice];
        if (bit_end) begin
          count_n = '0;
          if (indice != 4'd15) begin
            indice_n = indice + 4'd1;
          end else begin
            indice_n = '0;
`ifdef UART_TX_PARIDADE_EN
            state_n  = PARIDADE;
`else
            state_n  = PARADA;
`endif
          end
        end else begin
          count_n = count + 13'd1;
        end
      end
`ifdef UART_TX_PARIDADE_EN
      PARIDADE: begin
        tx_n = parity;
        if (bit_end) begin
          count_n = '0;
          state_n = PARADA;
        end else begin
          count_n = count + 13'd1;
        end
      end
`endif
      PARADA: begin
        tx_n = 1'b1;
        if (bit_end) begin
          count_n = '0;
          done_n  = 1'b1;
          state_n = LIMPEZA;
        end else begin
          count_n = count + 13'd1;
        end
      end
      LIMPEZA: begin
        done_n   = 1'b0;
        active_n = 1'b0;
        state_n  = ESPERA;
      end
      default: begin
        tx_n     = 1'b1;
        done_n   = 1'b0;
        active_n = 1'b0;
        count_n  = '0;
        indice_n = '0;
        state_n  = ESPERA;
      end
    endcase
  end

endmodule
